// File: rtl/alu_muldiv_seq.sv
// Iterative radix-2 multiply/divide unit (RISC-V M funct3 decode), one bit per clock.
// Optional ALU_MULDIV_EARLY_OUT_EN: special cases bypass CALC and finish in two cycles.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [2:0]       CONTROL,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULTADO,
    output logic             ZERO
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_busy;
    logic               r_done;
    logic               r_zero;
    logic [WIDTH-1:0]   r_res;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_x;
    logic               r_neg;
    logic               r_dz;
    logic               r_ovf;
    logic [WIDTH:0]     r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opd;

    logic               w_xs;
    logic               w_ys;
    logic [WIDTH-1:0]   w_xmag;
    logic [WIDTH-1:0]   w_ymag;
    logic               w_dz;
    logic               w_ovf;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quot_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_res;
`ifdef ALU_MULDIV_EARLY_OUT_EN
    logic               r_mz;
    logic               w_mz;
    logic               w_early;
`endif

    // Operand sign/magnitude decode and special-case detection on the request
    assign w_xs   = X[WIDTH-1] & ((CONTROL == 3'b001) | (CONTROL == 3'b010) |
                                  (CONTROL == 3'b100) | (CONTROL == 3'b110));
    assign w_ys   = Y[WIDTH-1] & ((CONTROL == 3'b001) | (CONTROL == 3'b100) |
                                  (CONTROL == 3'b110));
    assign w_xmag = w_xs ? (-X) : X;
    assign w_ymag = w_ys ? (-Y) : Y;
    assign w_dz   = CONTROL[2] & (Y == {WIDTH{1'b0}});
    assign w_ovf  = CONTROL[2] & ~CONTROL[0] & (X == {1'b1, {(WIDTH-1){1'b0}}}) &
                    (Y == {WIDTH{1'b1}});
`ifdef ALU_MULDIV_EARLY_OUT_EN
    assign w_mz    = ~CONTROL[2] & ((X == {WIDTH{1'b0}}) | (Y == {WIDTH{1'b0}}));
    assign w_early = w_dz | w_ovf | w_mz;
`endif

    // Per-step datapath: shift-add for multiply, restoring subtract for divide
    assign w_add    = r_hi + {1'b0, (r_lo[0] ? r_opd : {WIDTH{1'b0}})};
    assign w_rem_sh = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_opd};
    assign w_prod   = {r_hi[WIDTH-1:0], r_lo};
    assign w_prod_s = r_neg ? (-w_prod) : w_prod;
    assign w_quot_s = r_neg ? (-r_lo) : r_lo;
    assign w_rem_s  = r_neg ? (-r_hi[WIDTH-1:0]) : r_hi[WIDTH-1:0];

    // Final result selection with sign correction and special-case overrides
    always_comb begin
        w_res = {WIDTH{1'b0}};
        case (r_op)
            3'b000:                 w_res = w_prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_res = w_prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_res = w_quot_s;
            3'b110, 3'b111:         w_res = w_rem_s;
            default:                w_res = {WIDTH{1'b0}};
        endcase
        if (r_dz) begin
            w_res = r_op[1] ? r_x : {WIDTH{1'b1}};
        end else if (r_ovf) begin
            w_res = r_op[1] ? {WIDTH{1'b0}} : r_x;
`ifdef ALU_MULDIV_EARLY_OUT_EN
        end else if (r_mz) begin
            w_res = {WIDTH{1'b0}};
`endif
        end else begin
            w_res = w_res;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
`ifdef ALU_MULDIV_EARLY_OUT_EN
                    w_state_nxt = w_early ? S_FIN : S_CALC;
`else
                    w_state_nxt = S_CALC;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and registered BUSY
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Operand capture, iteration registers and result/flag outputs
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_done <= 1'b0;
            r_zero <= 1'b0;
            r_res  <= {WIDTH{1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_op   <= 3'b000;
            r_x    <= {WIDTH{1'b0}};
            r_neg  <= 1'b0;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
            r_hi   <= {(WIDTH+1){1'b0}};
            r_lo   <= {WIDTH{1'b0}};
            r_opd  <= {WIDTH{1'b0}};
`ifdef ALU_MULDIV_EARLY_OUT_EN
            r_mz   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_op  <= CONTROL;
                        r_x   <= X;
                        r_neg <= (CONTROL[2] & CONTROL[1]) ? w_xs : (w_xs ^ w_ys);
                        r_dz  <= w_dz;
                        r_ovf <= w_ovf;
                        r_cnt <= CW'(WIDTH-1);
                        r_hi  <= {(WIDTH+1){1'b0}};
                        // multiply: shift multiplier (Y) out of r_lo; divide: dividend in r_lo
                        r_lo  <= CONTROL[2] ? w_xmag : w_ymag;
                        r_opd <= CONTROL[2] ? w_ymag : w_xmag;
`ifdef ALU_MULDIV_EARLY_OUT_EN
                        r_mz  <= w_mz;
`endif
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_op[2]) begin
                        if (!w_diff[WIDTH+1]) begin
                            r_hi <= w_diff[WIDTH:0];
                            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_hi <= w_rem_sh;
                            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= {1'b0, w_add[WIDTH:1]};
                        r_lo <= {w_add[0], r_lo[WIDTH-1:1]};
                    end
                end
                S_FIN: begin
                    r_res  <= w_res;
                    r_zero <= (w_res == {WIDTH{1'b0}});
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign RESULTADO = r_res;
    assign ZERO      = r_zero;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq (WIDTH=32); honours ALU_MULDIV_EARLY_OUT_EN.
module tb_alu_muldiv_seq;

    localparam int W = 32;
`ifdef ALU_MULDIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = W + 1;
`endif

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          START = 1'b0;
    logic [2:0]    CONTROL = 3'b000;
    logic [W-1:0]  X = '0;
    logic [W-1:0]  Y = '0;
    logic          BUSY;
    logic          DONE;
    logic [W-1:0]  RESULTADO;
    logic          ZERO;

    int n_total = 0;
    int n_bad   = 0;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .CONTROL(CONTROL),
        .X(X), .Y(Y), .BUSY(BUSY), .DONE(DONE), .RESULTADO(RESULTADO), .ZERO(ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] ctl, input logic [31:0] x, input logic [31:0] y);
        @(negedge CLK);
        CONTROL = ctl; X = x; Y = y; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(output int n, output int nb);
        n = 0; nb = 0;
        while (DONE !== 1'b1 && n < 200) begin
            if (BUSY === 1'b1) nb++;
            @(posedge CLK); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] ctl, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input bit spec);
        int n, nb;
        launch(ctl, x, y);
        wait_done(n, nb);
        chk({tag, "_done"}, {31'd0, DONE}, 32'd1);
        chk({tag, "_res"}, RESULTADO, exp);
        chk({tag, "_zero"}, {31'd0, ZERO}, {31'd0, exp == 32'd0});
        chk({tag, "_lat"}, n, spec ? SPEC_LAT : W + 1);
        @(posedge CLK); #1;
        chk({tag, "_pulse"}, {31'd0, DONE}, 32'd0);
    endtask

    initial begin
        int n, nb, dcnt;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_res", RESULTADO, 32'd0);
        chk("rst_zero", {31'd0, ZERO}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // full-latency MUL with BUSY duration
        launch(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done(n, nb);
        chk("mul_busy", nb, 32'd33);
        chk("mul_lat", n, 32'd33);
        chk("mul_res", RESULTADO, 32'hFFFF_FFEB);
        chk("mul_zero", {31'd0, ZERO}, 32'd0);
        chk("mul_busy_at_done", {31'd0, BUSY}, 32'd0);
        @(posedge CLK); #1;
        chk("mul_pulse", {31'd0, DONE}, 32'd0);

        run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mul_big", 3'b000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0);
        run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("divu", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0);
        run_op("remu", 3'b111, 32'd7, 32'd2, 32'd1, 1'b0);
        run_op("div_neg_y", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
        run_op("rem_neg_y", 3'b110, 32'd100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op("remu0", 3'b111, 32'd5, 32'd0, 32'd5, 1'b1);
        run_op("rem0_neg", 3'b110, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFF6, 1'b1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
        run_op("mul_x0", 3'b001, 32'd0, 32'h1234_5678, 32'd0, 1'b1);

        // START and operand changes while busy are ignored
        launch(3'b100, 32'd100, 32'd7);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        START = 1'b1; CONTROL = 3'b000; X = 32'd3; Y = 32'd3;
        @(posedge CLK); #1;
        START = 1'b0; X = 32'd55; Y = 32'd1;
        wait_done(n, nb);
        chk("intf_lat", n + 5, 32'd33);
        chk("intf_res", RESULTADO, 32'd14);
        @(posedge CLK); #1;
        chk("intf_busy", {31'd0, BUSY}, 32'd0);

        // back-to-back: second START in the DONE cycle, result held meanwhile
        launch(3'b000, 32'd6, 32'd7);
        wait_done(n, nb);
        chk("b2b_first", RESULTADO, 32'd42);
        CONTROL = 3'b101; X = 32'd100; Y = 32'd7; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        n = 1;
        while (DONE !== 1'b1 && n < 200) begin
            chk("b2b_hold", RESULTADO, 32'd42);
            @(posedge CLK); #1;
            n++;
        end
        chk("b2b_lat", n, 32'd34);
        chk("b2b_res", RESULTADO, 32'd14);

        // reset mid-operation aborts without DONE
        launch(3'b000, 32'd9, 32'd9);
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b0;
        @(posedge CLK); #1;
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_res", RESULTADO, 32'd0);
        chk("abort_zero", {31'd0, ZERO}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) dcnt++;
        end
        chk("abort_nodone", dcnt, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
